// File: rtl/wb_sram_if.sv
// Wishbone classic slave-side bundle for wb_sram_slave.
// wb_err_o exists only when WB_SRAM_ERR_EN is defined.
interface wb_sram_if #(
  parameter int DW = 16
);
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic [31:0]     wb_adr_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;
`ifdef WB_SRAM_ERR_EN
  logic            wb_err_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i,
    output wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i,
    input  wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
`else
  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i,
    output wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i,
    input  wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
`endif
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic single-port RAM slave with wait states.
// Define WB_SRAM_ERR_EN to flag out-of-range addresses on wb_err_o.
module wb_sram_slave #(
  parameter int data_width  = 16,
  parameter int depth_log2  = 10,
  parameter int wait_states = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb_sram_if.slave wb
);
  localparam int SW  = data_width / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = depth_log2 + OFF;
  localparam logic [3:0] WS_M1 =
    (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dat_q, dat_d;
  logic [data_width-1:0] mem_q [2**depth_log2];

  logic                  req;
  logic                  go;
  logic                  ok;
  logic [depth_log2-1:0] idx;
  logic                  unused_adr;

  assign req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign idx        = wb.wb_adr_i[IW-1:OFF];
  assign unused_adr = ^wb.wb_adr_i;

`ifdef WB_SRAM_ERR_EN
  logic err_q, err_d;

  assign ok          = (wb.wb_adr_i >> IW) == 32'd0;
  assign wb.wb_err_o = err_q;
`else
  assign ok = 1'b1;
`endif

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (wait_states == 0) begin
            go = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_M1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go) state_d = ACK;
    ack_d = go & ok;
    dat_d = dat_q;
    if (go && ok && !wb.wb_we_i) dat_d = mem_q[idx];
  end

`ifdef WB_SRAM_ERR_EN
  assign err_d = go & ~ok;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
`ifdef WB_SRAM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
`ifdef WB_SRAM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // RAM has no reset; a transfer interrupted by reset never commits.
  always_ff @(posedge clk_i) begin
    if (!rst_i && go && ok && wb.wb_we_i) begin
      for (int k = 0; k < SW; k++) begin
        if (wb.wb_sel_i[k]) begin
          mem_q[idx][8*k +: 8] <= wb.wb_dat_i[8*k +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: ws=0 and ws=3 instances
// against a cycle-count reference model.
`timescale 1ns/1ps
module tb_wb_sram_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_sram_if #(.DW(16)) b0 ();
  wb_sram_if #(.DW(16)) b3 ();

  wb_sram_slave #(
    .data_width(16), .depth_log2(10), .wait_states(0)
  ) u0 (.clk_i(clk), .rst_i(rst), .wb(b0));

  wb_sram_slave #(
    .data_width(16), .depth_log2(10), .wait_states(3)
  ) u3 (.clk_i(clk), .rst_i(rst), .wb(b3));

  logic        cyc_t [2];
  logic        stb_t [2];
  logic        we_t  [2];
  logic [31:0] adr_t [2];
  logic [1:0]  sel_t [2];
  logic [15:0] dat_t [2];
  logic        ack_t [2];
  logic        err_t [2];
  logic [15:0] dato_t[2];

  assign b0.wb_cyc_i = cyc_t[0];
  assign b0.wb_stb_i = stb_t[0];
  assign b0.wb_we_i  = we_t[0];
  assign b0.wb_adr_i = adr_t[0];
  assign b0.wb_sel_i = sel_t[0];
  assign b0.wb_dat_i = dat_t[0];
  assign ack_t[0]    = b0.wb_ack_o;
  assign dato_t[0]   = b0.wb_dat_o;
  assign b3.wb_cyc_i = cyc_t[1];
  assign b3.wb_stb_i = stb_t[1];
  assign b3.wb_we_i  = we_t[1];
  assign b3.wb_adr_i = adr_t[1];
  assign b3.wb_sel_i = sel_t[1];
  assign b3.wb_dat_i = dat_t[1];
  assign ack_t[1]    = b3.wb_ack_o;
  assign dato_t[1]   = b3.wb_dat_o;
`ifdef WB_SRAM_ERR_EN
  assign err_t[0] = b0.wb_err_o;
  assign err_t[1] = b3.wb_err_o;
`else
  assign err_t[0] = 1'b0;
  assign err_t[1] = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic [15:0] mm [2][1024];
  bit          act  [2];
  int          start[2];
  bit          eack [2];
  bit          eerr [2];
  logic [15:0] edat [2];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic complete(int d);
    int idx = int'((adr_t[d] >> 1) & 32'd1023);
    bit oob = 1'b0;
`ifdef WB_SRAM_ERR_EN
    oob = (adr_t[d] >> 11) != 32'd0;
`endif
    if (oob) begin
      eerr[d] = 1'b1;
    end else begin
      eack[d] = 1'b1;
      if (we_t[d]) begin
        for (int k = 0; k < 2; k++)
          if (sel_t[d][k]) mm[d][idx][8*k +: 8] = dat_t[d][8*k +: 8];
      end else begin
        edat[d] = mm[d][idx];
      end
    end
  endtask

  // A request sampled at edge n completes at edge n+ws;
  // the edge after a completion never starts a new one.
  task automatic model(int d);
    int ws   = (d == 0) ? 0 : 3;
    bit done = eack[d] | eerr[d];
    bit req  = cyc_t[d] & stb_t[d];
    eack[d] = 1'b0;
    eerr[d] = 1'b0;
    if (rst) begin
      act[d]  = 1'b0;
      edat[d] = 16'h0;
    end else if (!done) begin
      if (!act[d] && req) begin
        act[d]   = 1'b1;
        start[d] = cyc_n;
      end else if (act[d] && !req) begin
        act[d] = 1'b0;
      end
      if (act[d] && (cyc_n - start[d]) == ws) begin
        act[d] = 1'b0;
        complete(d);
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      model(d);
      chk($sformatf("cmp_ack%0d", d), 32'(ack_t[d]), 32'(eack[d]));
      chk($sformatf("cmp_err%0d", d), 32'(err_t[d]), 32'(eerr[d]));
      chk($sformatf("cmp_dat%0d", d), 32'(dato_t[d]), 32'(edat[d]));
      chk($sformatf("cmp_excl%0d", d),
          32'(ack_t[d] & err_t[d]), 32'd0);
    end
  end

  task automatic req_on(int d, bit we, logic [31:0] adr,
                        logic [1:0] sel, logic [15:0] dat);
    @(negedge clk);
    cyc_t[d] = 1'b1;
    stb_t[d] = 1'b1;
    we_t[d]  = we;
    adr_t[d] = adr;
    sel_t[d] = sel;
    dat_t[d] = dat;
  endtask

  task automatic req_off(int d);
    cyc_t[d] = 1'b0;
    stb_t[d] = 1'b0;
  endtask

  task automatic wait_done(int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ack_t[d] | err_t[d]) && lat < 40);
    if (!(ack_t[d] | err_t[d])) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: got no ack expected ack", d);
    end
  endtask

  task automatic xfer(int d, bit we, logic [31:0] adr,
                      logic [1:0] sel, logic [15:0] dat,
                      output int lat, output logic [15:0] rd,
                      output bit er);
    req_on(d, we, adr, sel, dat);
    wait_done(d, lat);
    rd = dato_t[d];
    er = err_t[d];
    req_off(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          n;
    logic [15:0] rd;
    bit          er;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cyc_t[d] = 1'b0; stb_t[d] = 1'b0; we_t[d] = 1'b0;
      adr_t[d] = '0;   sel_t[d] = '0;   dat_t[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack0", 32'(ack_t[0]), 32'd0);
    chk("rst_dat0", 32'(dato_t[0]), 32'd0);
    chk("rst_dat3", 32'(dato_t[1]), 32'd0);
    rst = 1'b0;

    xfer(0, 1'b1, 32'h4, 2'b11, 16'hBEEF, lat, rd, er);
    chk("t1_wr_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h4, 2'b11, 16'h0, lat, rd, er);
    chk("t1_rd_lat", 32'(lat), 32'd1);
    chk("t1_rd_dat", 32'(rd), 32'hBEEF);

    xfer(0, 1'b1, 32'h4, 2'b01, 16'h1234, lat, rd, er);
    xfer(0, 1'b0, 32'h4, 2'b11, 16'h0, lat, rd, er);
    chk("t2_lane", 32'(rd), 32'hBE34);
    xfer(0, 1'b1, 32'h4, 2'b00, 16'hFFFF, lat, rd, er);
    chk("t2_sel0_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h4, 2'b11, 16'h0, lat, rd, er);
    chk("t2_sel0_dat", 32'(rd), 32'hBE34);

    req_on(0, 1'b0, 32'h4, 2'b11, 16'h0);
    wait_done(0, lat);
    wait_done(0, lat);
    chk("t3_b2b_ws0", 32'(lat), 32'd2);
    req_off(0);

    xfer(1, 1'b1, 32'h8, 2'b11, 16'hC3C3, lat, rd, er);
    chk("t3_wr_lat", 32'(lat), 32'd4);
    req_on(1, 1'b0, 32'h8, 2'b11, 16'h0);
    wait_done(1, lat);
    chk("t3_rd_lat", 32'(lat), 32'd4);
    chk("t3_rd_dat", 32'(dato_t[1]), 32'hC3C3);
    wait_done(1, lat);
    chk("t3_b2b_ws3", 32'(lat), 32'd5);
    req_off(1);

    req_on(1, 1'b1, 32'h8, 2'b11, 16'hAAAA);
    n = 0;
    repeat (2) begin
      @(negedge clk);
      n += int'(ack_t[1]);
    end
    stb_t[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n += int'(ack_t[1]);
    end
    chk("t4_no_ack", 32'(n), 32'd0);
    req_off(1);
    xfer(1, 1'b0, 32'h8, 2'b11, 16'h0, lat, rd, er);
    chk("t4_old", 32'(rd), 32'hC3C3);

    xfer(1, 1'b1, 32'h10, 2'b11, 16'h1111, lat, rd, er);
    xfer(1, 1'b0, 32'h8, 2'b11, 16'h0, lat, rd, er);
    req_on(1, 1'b1, 32'h10, 2'b11, 16'h5555);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_off(1);
    @(negedge clk);
    chk("t5_ack", 32'(ack_t[1]), 32'd0);
    chk("t5_dat", 32'(dato_t[1]), 32'd0);
    rst = 1'b0;
    xfer(1, 1'b0, 32'h10, 2'b11, 16'h0, lat, rd, er);
    chk("t5_nocommit", 32'(rd), 32'h1111);

    xfer(0, 1'b1, 32'h0, 2'b11, 16'h0F0F, lat, rd, er);
    xfer(0, 1'b1, 32'h800, 2'b11, 16'h7777, lat, rd, er);
`ifdef WB_SRAM_ERR_EN
    chk("t6_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 32'h0, 2'b11, 16'h0, lat, rd, er);
    chk("t6_ram0", 32'(rd), 32'h0F0F);
`else
    chk("t6_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h0, 2'b11, 16'h0, lat, rd, er);
    chk("t6_alias", 32'(rd), 32'h7777);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
